// File: rtl/mcu_spi_pkg.sv
// Shared constants and types for the MCU SPI slave: target codes, FSM states, default ID.
package mcu_spi_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned TGT_W  = 2;
  localparam int unsigned NUM_CLIENTS = 3;

  localparam logic [TGT_W-1:0] TGT_NONE = 2'd0;
  localparam logic [TGT_W-1:0] TGT_HID  = 2'd1;
  localparam logic [TGT_W-1:0] TGT_OSD  = 2'd2;
  localparam logic [TGT_W-1:0] TGT_SDC  = 2'd3;

  localparam logic [BYTE_W-1:0] MCU_ID_DEFAULT = 8'h5C;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TARGET  = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  // One-hot client select, bit order {sdc, osd, hid}; unmapped codes select nobody.
  function automatic logic [NUM_CLIENTS-1:0] tgt_onehot(input logic [TGT_W-1:0] tgt);
    case (tgt)
      TGT_HID: return 3'b001;
      TGT_OSD: return 3'b010;
      TGT_SDC: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mcu_spi_if.sv
// Byte-stream bus between the MCU SPI slave and its hid/osd/sdc clients.
interface mcu_spi_if;
  import mcu_spi_pkg::*;

  logic              hid_strobe, osd_strobe, sdc_strobe;
  logic              hid_start,  osd_start,  sdc_start;
  logic [BYTE_W-1:0] hid_din,    osd_din,    sdc_din;
  logic [BYTE_W-1:0] hid_dout,   osd_dout,   sdc_dout;

  modport master (
    output hid_strobe, osd_strobe, sdc_strobe,
    output hid_start,  osd_start,  sdc_start,
    output hid_din,    osd_din,    sdc_din,
    input  hid_dout,   osd_dout,   sdc_dout
  );

  modport slave (
    input  hid_strobe, osd_strobe, sdc_strobe,
    input  hid_start,  osd_start,  sdc_start,
    input  hid_din,    osd_din,    sdc_din,
    output hid_dout,   osd_dout,   sdc_dout
  );

endinterface

// File: rtl/mcu_spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous SPI line with rise/fall detection on the synced level.
module mcu_spi_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q      = sync_q[STAGES-1];
  assign rise_c =  sync_q[STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/mcu_spi.sv
// SPI slave (mode 0, MSB first) from the IO MCU: first byte selects a client, later bytes
// are streamed to it as strobe/start/din while its dout byte is returned on MISO.
module mcu_spi
  import mcu_spi_pkg::*;
#(
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] MCU_ID      = MCU_ID_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_io_ss,
  input  logic       spi_io_clk,
  input  logic       spi_io_din,
  output logic       spi_io_dout,
  mcu_spi_if.master  client
);

  logic ss_q, ss_rise_c, ss_fall_c;
  logic sclk_lvl_unused, sclk_rise_c, sclk_fall_c;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic din_s;

  mcu_spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk(clk), .reset(reset), .d(spi_io_ss),
    .q(ss_q), .rise_c(ss_rise_c), .fall_c(ss_fall_c)
  );

  mcu_spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset(reset), .d(spi_io_clk),
    .q(sclk_lvl_unused), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
  );

  // MOSI needs the same latency as SCLK so it is stable when the synced rise is seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) din_sync_q <= '0;
    else       din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], spi_io_din};
  end
  assign din_s = din_sync_q[SYNC_STAGES-1];

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]      rx_q, rx_d, tx_q, tx_d, reply_c;
  logic [TGT_W-1:0]       target_q, target_d;
  logic                   first_q, first_d;
  logic                   byte_done_q, byte_done_d;
  logic [1:0]             reload_q, reload_d;
  logic [NUM_CLIENTS-1:0] strobe_d;
  logic                   start_d, dout_d;

  always_comb begin
    case (target_q)
      TGT_HID: reply_c = client.hid_dout;
      TGT_OSD: reply_c = client.osd_dout;
      TGT_SDC: reply_c = client.sdc_dout;
      default: reply_c = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    target_d    = target_q;
    first_d     = first_q;
    byte_done_d = 1'b0;
    reload_d    = {reload_q[0], 1'b0};
    strobe_d    = '0;
    start_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ss_fall_c) begin
          state_d   = ST_TARGET;
          tx_d      = MCU_ID;
          bit_cnt_d = '0;
        end
      end
      ST_TARGET, ST_PAYLOAD: begin
        if (sclk_rise_c) begin
          rx_d        = {rx_q[BYTE_W-2:0], din_s};
          bit_cnt_d   = bit_cnt_q + CNT_W'(1);
          byte_done_d = (bit_cnt_q == CNT_W'(7));
        end
        // The fall after the 8th rise ends the byte; skipping it keeps a reloaded MSB on the line.
        if (sclk_fall_c && (bit_cnt_q != '0)) begin
          tx_d = {tx_q[BYTE_W-2:0], 1'b0};
        end
        if (byte_done_q) begin
          if (state_q == ST_TARGET) begin
            target_d = rx_q[TGT_W-1:0];
            first_d  = 1'b1;
            state_d  = ST_PAYLOAD;
          end else begin
            strobe_d    = tgt_onehot(target_q);
            start_d     = first_q;
            first_d     = 1'b0;
            reload_d[0] = 1'b1;
          end
        end
        // Client dout is taken two cycles after the strobe, giving it one cycle to respond.
        if (reload_q[1]) begin
          tx_d = reply_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Chip-select release wins over everything, including a byte completing this cycle.
    if (ss_rise_c) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = '0;
      byte_done_d = 1'b0;
      reload_d    = '0;
      strobe_d    = '0;
      start_d     = 1'b0;
    end

    dout_d = ss_q ? 1'b1 : tx_d[BYTE_W-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      target_q    <= TGT_NONE;
      first_q     <= 1'b0;
      byte_done_q <= 1'b0;
      reload_q    <= '0;
      spi_io_dout <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      target_q    <= target_d;
      first_q     <= first_d;
      byte_done_q <= byte_done_d;
      reload_q    <= reload_d;
      spi_io_dout <= dout_d;
    end
  end

  // Client-facing outputs; an unselected client holds its last din.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      client.hid_strobe <= 1'b0;
      client.osd_strobe <= 1'b0;
      client.sdc_strobe <= 1'b0;
      client.hid_start  <= 1'b0;
      client.osd_start  <= 1'b0;
      client.sdc_start  <= 1'b0;
      client.hid_din    <= '0;
      client.osd_din    <= '0;
      client.sdc_din    <= '0;
    end else begin
      client.hid_strobe <= strobe_d[0];
      client.osd_strobe <= strobe_d[1];
      client.sdc_strobe <= strobe_d[2];
      client.hid_start  <= strobe_d[0] & start_d;
      client.osd_start  <= strobe_d[1] & start_d;
      client.sdc_start  <= strobe_d[2] & start_d;
      if (strobe_d[0]) client.hid_din <= rx_q;
      if (strobe_d[1]) client.osd_din <= rx_q;
      if (strobe_d[2]) client.sdc_din <= rx_q;
    end
  end

endmodule
